// File: rtl/div_pkg.sv
// Shared types and constants for the 8-by-4 restoring divider.
package div_pkg;

  localparam int unsigned DIVIDEND_W = 8;
  localparam int unsigned DIVISOR_W  = 4;
  localparam int unsigned STEP_COUNT = 8;
  localparam int unsigned CNT_W      = $clog2(STEP_COUNT);

  // Counter value seen on the edge that completes the final step
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEP_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: compare the shifted partial remainder
// against the divisor and subtract when it fits.
module div_step
  import div_pkg::*;
(
  input  logic [DIVISOR_W:0]   rem_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W-1:0] rem_o,
  output logic                 q_bit_o
);

  // Compare/subtract; the kept remainder is always below the divisor, so 4 bits suffice
  always_comb begin
    q_bit_o = (rem_i >= {1'b0, divisor_i});
    rem_o   = q_bit_o ? DIVISOR_W'(rem_i - {1'b0, divisor_i}) : rem_i[DIVISOR_W-1:0];
  end

endmodule

// File: rtl/tt_um_carlosgs99_div_8by4.sv
// 8-bit by 4-bit sequential restoring divider, one quotient bit per cycle.
// Optional macro DIV_ZERO_SHORTCUT_EN: a zero divisor finishes after a single
// RUN cycle instead of stepping through all eight bits.
module tt_um_carlosgs99_div_8by4
  import div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] io_Dividend,
  input  logic [DIVISOR_W-1:0]  io_Divisor,
  output logic [DIVIDEND_W-1:0] io_Quotient,
  output logic [DIVISOR_W-1:0]  io_Remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  div0
);

  div_state_e            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DIVIDEND_W-1:0] dvd_q;   // dividend, shifted left as bits are consumed
  logic [DIVISOR_W-1:0]  dvs_q;
  logic [DIVISOR_W-1:0]  rem_q;
  logic [DIVIDEND_W-1:0] quo_q;

  logic [DIVISOR_W:0]    step_in;
  logic [DIVISOR_W-1:0]  step_rem;
  logic                  step_q;
  logic                  zero_short;

  assign step_in = {rem_q, dvd_q[DIVIDEND_W-1]};

  div_step u_step (
    .rem_i     (step_in),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

`ifdef DIV_ZERO_SHORTCUT_EN
  assign zero_short = (dvs_q == '0);
`else
  assign zero_short = 1'b0;
`endif

  // Control FSM, datapath and registered result; ena low freezes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dvd_q        <= '0;
      dvs_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      io_Quotient  <= '0;
      io_Remainder <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      div0         <= 1'b0;
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q   <= io_Dividend;
            dvs_q   <= io_Divisor;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (zero_short) begin
            io_Quotient  <= '1;
            io_Remainder <= dvd_q[DIVISOR_W-1:0];
            div0         <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b1;
            state_q      <= DONE;
          end else begin
            rem_q <= step_rem;
            quo_q <= {quo_q[DIVIDEND_W-2:0], step_q};
            dvd_q <= {dvd_q[DIVIDEND_W-2:0], 1'b0};
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
              io_Quotient  <= {quo_q[DIVIDEND_W-2:0], step_q};
              io_Remainder <= step_rem;
              div0         <= (dvs_q == '0);
              busy         <= 1'b0;
              done         <= 1'b1;
              state_q      <= DONE;
            end
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_um_carlosgs99_div_8by4.sv
// Scoreboard bench for the 8-by-4 divider: stimulus pushes expected results,
// a negedge monitor pops and checks them whenever done is seen.
module tb_tt_um_carlosgs99_div_8by4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       start = 1'b0;
  logic [7:0] io_Dividend = '0;
  logic [3:0] io_Divisor = '0;
  logic [7:0] io_Quotient;
  logic [3:0] io_Remainder;
  logic       busy;
  logic       done;
  logic       div0;

  tt_um_carlosgs99_div_8by4 dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .start        (start),
    .io_Dividend  (io_Dividend),
    .io_Divisor   (io_Divisor),
    .io_Quotient  (io_Quotient),
    .io_Remainder (io_Remainder),
    .busy         (busy),
    .done         (done),
    .div0         (div0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       d0;
    int         at;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] last_q = '0;
  logic [3:0] last_r = '0;

`ifdef DIV_ZERO_SHORTCUT_EN
  localparam bit Shortcut = 1'b1;
`else
  localparam bit Shortcut = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done cycle must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", int'(io_Quotient), int'(e.q));
        chk("remainder", int'(io_Remainder), int'(e.r));
        chk("div0", int'(div0), int'(e.d0));
        chk("done_cycle", cyc, e.at);
      end
    end
  end

  // Issue one division; stall = cycles of ena low mid-RUN, intrude = extra start while busy
  task automatic run_div(input logic [7:0] a, input logic [3:0] b, input logic [7:0] eq,
                         input logic [3:0] er, input logic ed0, input int stall,
                         input bit intrude);
    int   c0;
    int   lat;
    int   n;
    int   busy_cnt;
    exp_t e;
    @(negedge clk);
    io_Dividend = a;
    io_Divisor  = b;
    start       = 1'b1;
    @(negedge clk);
    c0          = cyc;
    start       = 1'b0;
    io_Dividend = ~a;
    io_Divisor  = b ^ 4'h9;
    lat         = (Shortcut && b == 4'd0) ? 1 : 8;
    e.q = eq;
    e.r = er;
    e.d0 = ed0;
    e.at = c0 + lat + stall;
    sb.push_back(e);
    n = 0;
    busy_cnt = 0;
    while (!done && n < 64) begin
      if (busy) busy_cnt++;
      if (n == 0) begin
        chk("hold_quotient", int'(io_Quotient), int'(last_q));
        chk("hold_remainder", int'(io_Remainder), int'(last_r));
      end
      if (intrude && n == 2) begin
        start       = 1'b1;
        io_Dividend = 8'd100;
        io_Divisor  = 4'd3;
      end
      if (stall > 0 && n == 3) ena = 1'b0;
      if (stall > 0 && n == 3 + stall) ena = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("done_timeout", int'(done), 1);
    chk("busy_cycles", busy_cnt, lat + stall);
    chk("busy_in_done", int'(busy), 0);
    // start is still high here when intruding, so the DONE->IDLE edge sees it
    @(negedge clk);
    start = 1'b0;
    chk("done_one_pulse", int'(done), 0);
    @(negedge clk);
    chk("no_queued_start", int'(busy), 0);
    last_q = eq;
    last_r = er;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_quotient", int'(io_Quotient), 0);
    chk("rst_remainder", int'(io_Remainder), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_div0", int'(div0), 0);
    rst = 1'b0;
    @(negedge clk);

    run_div(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 0, 1'b0);
    run_div(8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 0, 1'b0);
    run_div(8'd9, 4'd12, 8'd0, 4'd9, 1'b0, 0, 1'b0);
    run_div(8'hA5, 4'd0, 8'hFF, 4'd5, 1'b1, 0, 1'b0);
    run_div(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 0, 1'b0);
    run_div(8'd0, 4'd5, 8'd0, 4'd0, 1'b0, 0, 1'b0);
    run_div(8'd40, 4'd6, 8'd6, 4'd4, 1'b0, 0, 1'b1);
    run_div(8'd77, 4'd9, 8'd8, 4'd5, 1'b0, 3, 1'b0);

    // Abandon a division with reset at RUN step 4
    @(negedge clk);
    io_Dividend = 8'd123;
    io_Divisor  = 4'd4;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_quotient", int'(io_Quotient), 0);
    chk("midrst_remainder", int'(io_Remainder), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_div0", int'(div0), 0);
    @(negedge clk);
    rst = 1'b0;
    last_q = '0;
    last_r = '0;
    run_div(8'd50, 4'd5, 8'd10, 4'd0, 1'b0, 0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
